led_pattern_engine: RTL and testbench

Parametrised multi-channel LED driver that replaces fixed per-LED status logic on the board.
Each of NUM_LEDS outputs independently selects one of several patterns:
- off, on, shared heartbeat
- programmable blink (period and duty)
- activity pulse-stretch
- numeric blink code

Mode, timing and event inputs come from PL status and control registers. All LED timing runs from one internal millisecond-class tick.

---
 rtl/led_pattern_pkg.sv | 36 +++
 rtl/led_channel.sv | 151 +++++++++++++++
 rtl/led_pattern_engine.sv | 107 ++++++++++
 tb/tb_led_pattern_engine.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, the
// blink-code FSM state type and elaboration-time sizing helpers.
package led_pattern_pkg;

  // Per-LED pattern selector; encodings 6 and 7 are unassigned and drive off.
  typedef enum logic [2:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_HB      = 3'd2,
    LED_BLINK   = 3'd3,
    LED_STRETCH = 3'd4,
    LED_CODE    = 3'd5
  } led_mode_e;

  // Blink-code sequencer states.
  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_ON   = 2'd1,
    CS_OFF  = 2'd2,
    CS_GAP  = 2'd3
  } code_state_e;

  // Clock cycles per pattern tick, never below one.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    if (tick_hz == 0) return 1;
    if (clk_hz / tick_hz < 1) return 1;
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to count 0..n-1, at least one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode register, blink phase, activity stretch counter,
// blink-code FSM and the registered output mux.
// Ports: clk/rst (sync, active-high), tick_i time-base strobe, hb_i shared
// heartbeat level, mode_i/period_i/on_time_i/event_i/code_i channel controls,
// led_o registered drive (1 = lit).
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned CODE_ON       = 250,
  parameter int unsigned CODE_OFF      = 250,
  parameter int unsigned CODE_GAP      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             hb_i,
  input  logic [2:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] on_time_i,
  input  logic             event_i,
  input  logic [3:0]       code_i,
  output logic             led_o
);

  localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'(STRETCH_TICKS);
  localparam logic [CNT_W-1:0] CODE_ON_LD = CNT_W'(CODE_ON);
  localparam logic [CNT_W-1:0] CODE_OFF_LD = CNT_W'(CODE_OFF);
  localparam logic [CNT_W-1:0] CODE_GAP_LD = CNT_W'(CODE_GAP);

  logic [2:0]       mode_q;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] str_q, str_d;
  code_state_e      cs_q, cs_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       rem_q, rem_d;
  logic             led_q, led_d;
  logic             mode_chg;

  // Next-state for all per-channel pattern state and the output mux.
  // State not belonging to the current mode is held at zero/IDLE.
  always_comb begin
    mode_chg = (mode_i != mode_q);
    phase_d  = '0;
    str_d    = '0;
    cs_d     = CS_IDLE;
    timer_d  = '0;
    rem_d    = '0;
    led_d    = 1'b0;

    // Blink phase; period of zero parks the phase at zero.
    if (!mode_chg && mode_i == LED_BLINK && period_i != '0) begin
      phase_d = phase_q;
      if (tick_i) begin
        phase_d = (phase_q >= period_i - CNT_W'(1)) ? '0 : phase_q + CNT_W'(1);
      end
    end

    // Stretch counter; an event load beats a coincident tick decrement.
    if (!mode_chg && mode_i == LED_STRETCH) begin
      str_d = str_q;
      if (event_i) begin
        str_d = STRETCH_LD;
      end else if (tick_i && str_q != '0) begin
        str_d = str_q - CNT_W'(1);
      end
    end

    // Blink-code sequencer; expiry is checked before the tick decrement so
    // a simultaneous tick never causes a double expiry.
    if (!mode_chg && mode_i == LED_CODE) begin
      cs_d    = cs_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      case (cs_q)
        CS_IDLE: begin
          if (code_i != 4'd0) begin
            rem_d   = code_i;
            timer_d = CODE_ON_LD;
            cs_d    = CS_ON;
          end
        end
        CS_ON: begin
          if (timer_q == '0) begin
            cs_d    = CS_OFF;
            timer_d = CODE_OFF_LD;
            rem_d   = rem_q - 4'd1;
          end else if (tick_i) begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        CS_OFF: begin
          if (timer_q == '0) begin
            if (rem_q != 4'd0) begin
              cs_d    = CS_ON;
              timer_d = CODE_ON_LD;
            end else begin
              cs_d    = CS_GAP;
              timer_d = CODE_GAP_LD;
            end
          end else if (tick_i) begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        CS_GAP: begin
          if (timer_q == '0) begin
            cs_d = CS_IDLE;
          end else if (tick_i) begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: cs_d = CS_IDLE;
      endcase
    end

    // Output mux from the live mode so simple modes respond in one cycle.
    case (mode_i)
      LED_ON:      led_d = 1'b1;
      LED_HB:      led_d = hb_i;
      LED_BLINK:   led_d = (period_i != '0) && (phase_q < on_time_i);
      LED_STRETCH: led_d = (str_q != '0) || (event_i && !mode_chg);
      LED_CODE:    led_d = (cs_q == CS_ON);
      default:     led_d = 1'b0;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      phase_q <= '0;
      str_q   <= '0;
      cs_q    <= CS_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      mode_q  <= mode_i;
      phase_q <= phase_d;
      str_q   <= str_d;
      cs_q    <= cs_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-channel LED pattern engine: shared tick prescaler and heartbeat plus
// NUM_LEDS independent pattern channels.
// Ports: clk/rst (sync, active-high); mode_i 3b/LED, period_i and on_time_i
// CNT_W/LED, event_i 1b/LED, code_i 4b/LED; led_o registered drive per LED;
// tick_o one-cycle time-base strobe.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned CLK_FREQ_HZ   = 84000000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned HB_PERIOD     = 1000,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned CODE_ON       = 250,
  parameter int unsigned CODE_OFF      = 250,
  parameter int unsigned CODE_GAP      = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3*NUM_LEDS-1:0]     mode_i,
  input  logic [CNT_W*NUM_LEDS-1:0] period_i,
  input  logic [CNT_W*NUM_LEDS-1:0] on_time_i,
  input  logic [NUM_LEDS-1:0]       event_i,
  input  logic [4*NUM_LEDS-1:0]     code_i,
  output logic [NUM_LEDS-1:0]       led_o,
  output logic                      tick_o
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int unsigned DIV_W = cnt_width(DIV);
  localparam int unsigned HB_W  = cnt_width(HB_PERIOD);
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Reject parameter sets the counters cannot represent.
  if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_num_leds
    $error("led_pattern_engine: NUM_LEDS must be 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("led_pattern_engine: CNT_W must be 1..32");
  end
  if (HB_PERIOD < 1) begin : g_bad_hb
    $error("led_pattern_engine: HB_PERIOD must be at least 1");
  end
  if (64'(STRETCH_TICKS) > CNT_MAX || 64'(CODE_ON) > CNT_MAX ||
      64'(CODE_OFF) > CNT_MAX || 64'(CODE_GAP) > CNT_MAX) begin : g_bad_ticks
    $error("led_pattern_engine: tick parameter exceeds CNT_W");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb;

  // Prescaler; tick is registered against the next count so it is high
  // exactly while the counter holds DIV-1.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_W'(DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
    tick_d    = (div_cnt_d == DIV_W'(DIV - 1));
  end

  // Shared heartbeat counter, 50% duty.
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    if (tick_q) begin
      hb_cnt_d = (hb_cnt_q == HB_W'(HB_PERIOD - 1)) ? '0 : hb_cnt_q + HB_W'(1);
    end
    hb = (hb_cnt_q < HB_W'(HB_PERIOD / 2));
  end

  // Time-base registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      hb_cnt_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      hb_cnt_q  <= hb_cnt_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .CNT_W        (CNT_W),
      .STRETCH_TICKS(STRETCH_TICKS),
      .CODE_ON      (CODE_ON),
      .CODE_OFF     (CODE_OFF),
      .CODE_GAP     (CODE_GAP)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_q),
      .hb_i     (hb),
      .mode_i   (mode_i[3*i +: 3]),
      .period_i (period_i[CNT_W*i +: CNT_W]),
      .on_time_i(on_time_i[CNT_W*i +: CNT_W]),
      .event_i  (event_i[i]),
      .code_i   (code_i[4*i +: 4]),
      .led_o    (led_o[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with DIV=10, HB_PERIOD=8,
// STRETCH_TICKS=3, CODE_ON=CODE_OFF=2, CODE_GAP=4. Cycle k counts clock
// edges since reset release; ticks fall in cycles where k%10 == 9.
module tb_led_pattern_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3*N-1:0]  mode;
  logic [CW*N-1:0] period;
  logic [CW*N-1:0] on_time;
  logic [N-1:0]    ev;
  logic [4*N-1:0]  code;
  logic [N-1:0]    led;
  logic            tick;

  int k      = 0;
  int checks = 0;
  int errors = 0;

  led_pattern_engine #(
    .NUM_LEDS(N), .CLK_FREQ_HZ(1000), .TICK_HZ(100), .CNT_W(CW),
    .HB_PERIOD(8), .STRETCH_TICKS(3), .CODE_ON(2), .CODE_OFF(2), .CODE_GAP(4)
  ) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .period_i(period),
    .on_time_i(on_time), .event_i(ev), .code_i(code),
    .led_o(led), .tick_o(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Advance to cycle t, sampling 1 time unit after the edge.
  task automatic at(input int t);
    while (k < t) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk4("rst_led", led, 4'b0000);
    chk("rst_tick", tick, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk4("rst_led_hold", led, 4'b0000);
    rst = 1'b0;
    k   = 0;
  endtask

  task automatic set_mode(input int ch, input logic [2:0] m);
    mode[3*ch +: 3] = m;
  endtask

  task automatic set_blink(input int ch, input logic [CW-1:0] p, input logic [CW-1:0] o);
    period[CW*ch +: CW]  = p;
    on_time[CW*ch +: CW] = o;
  endtask

  initial begin
    rst = 1'b0; mode = '0; period = '0; on_time = '0; ev = '0; code = '0;
    set_mode(1, 3'd1);
    set_mode(2, 3'd2);
    do_reset();

    // Off / on / heartbeat and tick cadence
    at(1);  chk("m0_off", led[0], 1'b0); chk("m1_on", led[1], 1'b1); chk("hb_start", led[2], 1'b1);
    at(8);  chk("tick_8", tick, 1'b0);
    at(9);  chk("tick_9", tick, 1'b1);
    at(10); chk("tick_10", tick, 1'b0);
    at(19); chk("tick_19", tick, 1'b1);
    at(40); chk("hb_hi_end", led[2], 1'b1);
    at(41); chk("hb_lo_start", led[2], 1'b0);
    at(50); chk("m1_pre", led[1], 1'b1); set_mode(1, 3'd0);
    at(51); chk("m1_off_lat", led[1], 1'b0);
    at(60); set_mode(1, 3'd1);
    at(61); chk("m1_on_lat", led[1], 1'b1);
    at(80); chk("hb_lo_end", led[2], 1'b0); chk("m0_still_off", led[0], 1'b0);
    at(81); chk("hb_wrap", led[2], 1'b1);

    // Blink period 5, on 2
    at(100); set_blink(3, 16'd5, 16'd2); set_mode(3, 3'd3);
    at(101); chk("bl_on0", led[3], 1'b1);
    at(120); chk("bl_on1", led[3], 1'b1);
    at(121); chk("bl_off0", led[3], 1'b0);
    at(150); chk("bl_off2", led[3], 1'b0);
    at(151); chk("bl_rep", led[3], 1'b1);
    at(171); chk("bl_rep_off", led[3], 1'b0);
    at(200); set_blink(3, 16'd0, 16'd2);
    at(201); chk("bl_p0", led[3], 1'b0);
    at(230); chk("bl_p0_hold", led[3], 1'b0); set_blink(3, 16'd5, 16'd7);
    at(231); chk("bl_solid", led[3], 1'b1);
    at(260); chk("bl_solid2", led[3], 1'b1);
    at(265); set_mode(3, 3'd0);
    at(266); chk("bl_rw_off", led[3], 1'b0); set_mode(3, 3'd3); set_blink(3, 16'd5, 16'd2);
    at(267); chk("bl_rw_phase0", led[3], 1'b1);
    at(280); chk("bl_rw_p1", led[3], 1'b1);
    at(281); chk("bl_rw_p2", led[3], 1'b0);

    // Stretch on LED0
    at(300); set_mode(0, 3'd4);
    at(303); chk("st_pre", led[0], 1'b0); ev[0] = 1'b1;
    at(304); ev[0] = 1'b0; chk("st_rise", led[0], 1'b1);
    at(330); chk("st_hold", led[0], 1'b1);
    at(331); chk("st_drop", led[0], 1'b0);
    at(343); ev[0] = 1'b1;
    at(344); ev[0] = 1'b0;
    at(362); ev[0] = 1'b1;
    at(363); ev[0] = 1'b0;
    at(371); chk("st_ext", led[0], 1'b1);
    at(390); chk("st_ext_end", led[0], 1'b1);
    at(391); chk("st_ext_drop", led[0], 1'b0);
    at(400); ev[0] = 1'b1;
    at(401); ev[0] = 1'b0;
    at(409); chk("st_tick_cyc", tick, 1'b1); ev[0] = 1'b1;
    at(410); ev[0] = 1'b0;
    at(431); chk("st_tick_load", led[0], 1'b1);
    at(440); chk("st_tick_end", led[0], 1'b1);
    at(441); chk("st_tick_drop", led[0], 1'b0);
    at(450); ev[0] = 1'b1;
    at(470); chk("st_level", led[0], 1'b1);
    at(481); ev[0] = 1'b0;
    at(510); chk("st_fall_hold", led[0], 1'b1);
    at(511); chk("st_fall_drop", led[0], 1'b0);

    // Blink code 3 on LED3
    at(600); set_mode(3, 3'd5); code[15:12] = 4'd3;
    at(602); chk("cd_idle", led[3], 1'b0);
    at(603); chk("cd_p1", led[3], 1'b1);
    at(621); chk("cd_p1_end", led[3], 1'b1);
    at(622); chk("cd_off1", led[3], 1'b0);
    at(641); chk("cd_off1_end", led[3], 1'b0);
    at(642); chk("cd_p2", led[3], 1'b1);
    at(661); chk("cd_p2_end", led[3], 1'b1);
    at(662); chk("cd_off2", led[3], 1'b0);
    at(682); chk("cd_p3", led[3], 1'b1);
    at(701); chk("cd_p3_end", led[3], 1'b1);
    at(702); chk("cd_no_p4", led[3], 1'b0);
    at(762); chk("cd_gap_end", led[3], 1'b0);
    at(763); chk("cd_repeat", led[3], 1'b1);
    at(770); code[15:12] = 4'd1;
    at(802); chk("cd_chg_p2", led[3], 1'b1);
    at(842); chk("cd_chg_p3", led[3], 1'b1);
    at(862); chk("cd_chg_off", led[3], 1'b0);
    at(922); chk("cd_new_idle", led[3], 1'b0);
    at(923); chk("cd_new_p1", led[3], 1'b1);
    at(941); chk("cd_new_p1_end", led[3], 1'b1);
    at(942); chk("cd_new_off", led[3], 1'b0);
    at(962); chk("cd_new_gap", led[3], 1'b0);
    at(1002); chk("cd_new_rep0", led[3], 1'b0);
    at(1003); chk("cd_new_rep", led[3], 1'b1); code[15:12] = 4'd0;
    at(1010); chk("cd_zero_run", led[3], 1'b1);
    at(1100); chk("cd_zero_off", led[3], 1'b0);
    at(1150); chk("cd_zero_off2", led[3], 1'b0);

    // All four modes together, reset mid-code, then restart
    at(1160);
    set_mode(0, 3'd2); set_mode(1, 3'd3); set_blink(1, 16'd5, 16'd2);
    set_mode(2, 3'd4); code[15:12] = 4'd3;
    at(1190);
    do_reset();
    at(1);  chk("ind_hb", led[0], 1'b1); chk("ind_bl", led[1], 1'b1);
    at(2);  chk("ind_cd_idle", led[3], 1'b0);
    at(3);  chk("ind_st_pre", led[2], 1'b0); chk("ind_cd_p1", led[3], 1'b1); ev[2] = 1'b1;
    at(4);  ev[2] = 1'b0; chk("ind_st_rise", led[2], 1'b1);
    at(9);  chk("ind_tick_9", tick, 1'b1);
    at(18); chk("ind_tick_18", tick, 1'b0);
    at(19); chk("ind_tick_19", tick, 1'b1);
    at(20); chk("ind_bl_on", led[1], 1'b1);
    at(21); chk("ind_bl_off", led[1], 1'b0); chk("ind_cd_p1_end", led[3], 1'b1);
    at(22); chk("ind_cd_off1", led[3], 1'b0);
    at(30); chk("ind_st_hold", led[2], 1'b1);
    at(31); chk("ind_st_drop", led[2], 1'b0);
    at(40); chk("ind_hb_hi", led[0], 1'b1);
    at(41); chk("ind_hb_lo", led[0], 1'b0);
    at(42); chk("ind_cd_p2", led[3], 1'b1);
    at(50); chk("ind_bl_off2", led[1], 1'b0);
    at(51); chk("ind_bl_rep", led[1], 1'b1);
    at(81); chk("ind_hb_wrap", led[0], 1'b1);
    at(102); chk("ind_cd_no_p4", led[3], 1'b0);
    at(162); chk("ind_cd_gap", led[3], 1'b0);
    at(163); chk("ind_cd_rep", led[3], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
